param_rr_arbiter: RTL

Round-robin arbiter that shares a single parameterized data/id sink among NUM_REQ requesters. Each requester presents a DATA_WIDTH data word and an ID_WIDTH id with a valid/ready handshake. The arbiter registers the winning transaction into a one-entry output stage that drives the shared `data`/`id` consumer. It is the sequencing layer placed in front of any `data`/`id` datapath whose widths are set by parameter override or defparam.

---
 rtl/param_rr_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/param_rr_arbiter.sv
// Round-robin arbiter sharing one registered data/id output stage among NUM_REQ requesters.
// Optional burst mode (repeat grants to the previous winner) is enabled by PARAM_ARB_BURST_EN.
module param_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_WIDTH-1:0]           out_id,
   output logic [$clog2(NUM_REQ)-1:0]    out_src,
   input  logic                          out_ready
);

   localparam int SRC_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("param_rr_arbiter: NUM_REQ must be in 2..16");
   end
   if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("param_rr_arbiter: MAX_BURST must be at least 1");
   end

   logic             load_en;
   logic             any_valid;
   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] rr_winner;
   logic [SRC_W-1:0] winner;
   logic [SRC_W-1:0] cand;

   assign load_en   = !out_valid || out_ready;
   assign any_valid = |req_valid;

   // First valid requester after ptr, wrapping modulo NUM_REQ.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rr_winner = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = SRC_W'((int'(ptr) + k) % NUM_REQ);
         if (req_valid[cand]) rr_winner = cand;
      end
   end

`ifdef PARAM_ARB_BURST_EN
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   logic [CNT_W-1:0] burst_cnt;
   logic             has_prev;
   logic             burst_hold;

   // has_prev keeps the reset value of ptr from being mistaken for a previous winner.
   assign burst_hold = has_prev && req_valid[ptr] && (int'(burst_cnt) < MAX_BURST - 1);
   assign winner     = burst_hold ? ptr : rr_winner;
`else
   assign winner = rr_winner;
`endif

   always_comb begin
      req_ready = '0;
      if (!rst && load_en && any_valid) req_ready[winner] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         out_src   <= '0;
         ptr       <= SRC_W'(NUM_REQ - 1);
`ifdef PARAM_ARB_BURST_EN
         burst_cnt <= '0;
         has_prev  <= 1'b0;
`endif
      end else if (load_en) begin
         if (any_valid) begin
            out_valid <= 1'b1;
            out_data  <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            out_id    <= req_id[int'(winner)*ID_WIDTH +: ID_WIDTH];
            out_src   <= winner;
            ptr       <= winner;
`ifdef PARAM_ARB_BURST_EN
            burst_cnt <= burst_hold ? burst_cnt + CNT_W'(1) : '0;
            has_prev  <= 1'b1;
`endif
         end else begin
            // Either drained by out_ready or already empty.
            out_valid <= 1'b0;
         end
      end
   end

endmodule
